// File: rtl/vector_list_buffer.sv
// Double-buffered vector display list: CPU fills the back bank, renderer reads the front bank,
// and swaps commit on vblank rising edges. Define VECTOR_LIST_AUTOCLEAR_EN to build the back-bank clear engine.
module vector_list_buffer #(
  parameter int LIST_RAM_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vblank,
  input  logic [15:0]               addr,
  input  logic [7:0]                data_in,
  input  logic                      write,
  output logic [7:0]                data_out,
  input  logic [LIST_RAM_WIDTH-1:0] rd_addr,
  output logic [7:0]                rd_data
);

  localparam int W     = LIST_RAM_WIDTH;
  localparam int DEPTH = 2 ** (W + 1);

  logic [7:0] mem [0:DEPTH-1];

  logic       front_bank;
  logic       swap_pending;
  logic       clear_busy;
  logic       vblank_last;
  logic [7:0] swaps;
  logic [7:0] stale;

  logic         reg_sel;
  logic [W-1:0] offset;
  logic [1:0]   reg_idx;
  logic         edge_det;
  logic         commit;
  logic         reg_wr;
  logic         list_wr;
  logic         unused_addr;

  assign reg_sel     = addr[W];
  assign offset      = addr[W-1:0];
  assign reg_idx     = addr[1:0];
  assign unused_addr = ^addr[15:W+1];

  assign edge_det = vblank & ~vblank_last;
  assign commit   = edge_det & swap_pending & ~clear_busy;
  assign reg_wr   = write & reg_sel;
  assign list_wr  = write & ~reg_sel & ~clear_busy;

  logic         clear_we;
  logic [W-1:0] clear_addr;

`ifdef VECTOR_LIST_AUTOCLEAR_EN
  typedef enum logic {IDLE, CLEAR} clear_state_t;

  clear_state_t state_reg, state_next;
  logic [W-1:0] clear_addr_reg, clear_addr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      clear_addr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      clear_addr_reg <= clear_addr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    clear_addr_next = clear_addr_reg;
    clear_we        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (commit) begin
          state_next      = CLEAR;
          clear_addr_next = '0;
        end
      end
      CLEAR: begin
        clear_we        = 1'b1;
        clear_addr_next = clear_addr_reg + 1'b1;
        if (&clear_addr_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign clear_busy = (state_reg == CLEAR);
  assign clear_addr = clear_addr_reg;
`else
  assign clear_busy = 1'b0;
  assign clear_we   = 1'b0;
  assign clear_addr = '0;
`endif

  // Both writers target the back bank; they never collide because CPU list writes are dropped while clearing.
  logic         ram_we;
  logic [W:0]   ram_waddr;
  logic [7:0]   ram_wdata;
  logic [W:0]   cpu_raddr;
  logic [W:0]   ren_raddr;

  assign ram_we    = ~reset & (list_wr | clear_we);
  assign ram_waddr = {~front_bank, (clear_we ? clear_addr : offset)};
  assign ram_wdata = clear_we ? 8'h00 : data_in;
  assign cpu_raddr = {~front_bank, offset};
  assign ren_raddr = {front_bank, rd_addr};

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= 8'h00;
    else       rd_data <= mem[ren_raddr];
  end

  logic [7:0] reg_rdata;

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_idx)
      2'd1:    reg_rdata = {5'b0, clear_busy, front_bank, swap_pending};
      2'd2:    reg_rdata = swaps;
      2'd3:    reg_rdata = stale;
      default: reg_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)           data_out <= 8'h00;
    else if (reg_sel)    data_out <= reg_rdata;
    else if (clear_busy) data_out <= 8'h00;
    else                 data_out <= mem[cpu_raddr];
  end

  // A CTRL write lands after the edge has been judged against the old swap_pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      swaps        <= 8'h00;
      stale        <= 8'h00;
      vblank_last  <= 1'b0;
    end else begin
      vblank_last <= vblank;
      if (commit) begin
        front_bank <= ~front_bank;
        swaps      <= swaps + 8'd1;
      end
      if (reg_wr && reg_idx == 2'd0 && data_in[1])      swap_pending <= 1'b0;
      else if (reg_wr && reg_idx == 2'd0 && data_in[0]) swap_pending <= 1'b1;
      else if (commit)                                  swap_pending <= 1'b0;
      if (reg_wr && reg_idx == 2'd3)                           stale <= 8'h00;
      else if (edge_det && !commit && stale != 8'hFF)          stale <= stale + 8'd1;
    end
  end

endmodule

// File: tb/tb_vector_list_buffer.sv
// Directed bench for vector_list_buffer with a bank-level reference model checked every cycle.
module tb_vector_list_buffer;

  localparam int LW = 9;
  localparam int N  = 2 ** LW;
`ifdef VECTOR_LIST_AUTOCLEAR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif

  localparam logic [15:0] A_CTRL   = 16'h0200;
  localparam logic [15:0] A_STATUS = 16'h0201;
  localparam logic [15:0] A_SWAPS  = 16'h0202;
  localparam logic [15:0] A_STALE  = 16'h0203;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vblank = 1'b0;
  logic [15:0]   addr = 16'h0;
  logic [7:0]    data_in = 8'h0;
  logic          write = 1'b0;
  logic [7:0]    data_out;
  logic [LW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;

  vector_list_buffer #(.LIST_RAM_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .addr(addr), .data_in(data_in),
    .write(write), .data_out(data_out), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Reference model: whole-bank view, clear is modelled as an instant zero plus a busy window.
  bit [7:0] m_mem [2*N];
  bit       m_known [2*N];
  bit       m_front, m_pend, m_vlast;
  int       m_busy_left, m_swaps, m_stale;
  bit       model_on = 1'b0;
  logic [7:0] exp_do, exp_rd;
  bit       exp_do_ok, exp_rd_ok;
  int       cyc_cnt = 0;

  bit         lit_do_en = 1'b0, lit_rd_en = 1'b0;
  logic [7:0] lit_do, lit_rd;
  string      lit_name = "";

  int checks = 0;
  int errors = 0;

  task automatic model_update();
    int ra, wa, back_base;
    bit busy, edge_v, commit;
    if (reset) begin
      back_base = m_front ? 0 : N;
      if (m_busy_left > 0)
        for (int i = N - m_busy_left; i < N; i++) m_known[back_base + i] = 1'b0;
      m_front = 0; m_pend = 0; m_vlast = 0; m_busy_left = 0; m_swaps = 0; m_stale = 0;
      exp_do = 8'h00; exp_do_ok = 1'b1; exp_rd = 8'h00; exp_rd_ok = 1'b1;
      model_on = 1'b1;
    end else begin
      busy = (m_busy_left > 0);
      ra = (m_front ? N : 0) + int'(rd_addr);
      wa = (m_front ? 0 : N) + int'(addr[LW-1:0]);
      exp_rd = m_mem[ra]; exp_rd_ok = m_known[ra];
      exp_do_ok = 1'b1;
      if (addr[LW]) begin
        case (addr[1:0])
          2'd1:    exp_do = {5'b0, busy, m_front, m_pend};
          2'd2:    exp_do = 8'(m_swaps);
          2'd3:    exp_do = 8'(m_stale);
          default: exp_do = 8'h00;
        endcase
      end else if (busy) begin
        exp_do = 8'h00;
      end else begin
        exp_do = m_mem[wa]; exp_do_ok = m_known[wa];
      end
      edge_v = vblank && !m_vlast;
      commit = edge_v && m_pend && !busy;
      if (write && !addr[LW] && !busy) begin
        m_mem[wa] = data_in; m_known[wa] = 1'b1;
      end
      if (busy) m_busy_left--;
      if (commit) begin
        m_front = !m_front;
        m_swaps = (m_swaps + 1) % 256;
        m_pend = 0;
        if (AUTOCLR) begin
          m_busy_left = N;
          back_base = m_front ? 0 : N;
          for (int i = 0; i < N; i++) begin
            m_mem[back_base + i] = 8'h00; m_known[back_base + i] = 1'b1;
          end
        end
      end
      if (write && addr[LW] && addr[1:0] == 2'd0) begin
        if (data_in[1])      m_pend = 0;
        else if (data_in[0]) m_pend = 1;
      end
      if (edge_v && !commit && m_stale < 255) m_stale++;
      if (write && addr[LW] && addr[1:0] == 2'd3) m_stale = 0;
      m_vlast = vblank;
    end
  endtask

  always @(negedge clk) begin
    if (model_on && exp_do_ok) begin
      checks++;
      if (data_out !== exp_do) begin
        errors++;
        $display("FAIL model_data_out cycle %0d: got %02h expected %02h", cyc_cnt, data_out, exp_do);
      end
    end
    if (model_on && exp_rd_ok) begin
      checks++;
      if (rd_data !== exp_rd) begin
        errors++;
        $display("FAIL model_rd_data cycle %0d: got %02h expected %02h", cyc_cnt, rd_data, exp_rd);
      end
    end
    if (lit_do_en) begin
      checks++;
      if (data_out !== lit_do) begin
        errors++;
        $display("FAIL %s: data_out got %02h expected %02h", lit_name, data_out, lit_do);
      end else $display("check %s: data_out=%02h ok", lit_name, data_out);
    end
    if (lit_rd_en) begin
      checks++;
      if (rd_data !== lit_rd) begin
        errors++;
        $display("FAIL %s: rd_data got %02h expected %02h", lit_name, rd_data, lit_rd);
      end else $display("check %s: rd_data=%02h ok", lit_name, rd_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_update();
    cyc_cnt++;
    @(negedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc_cnt < c) cyc();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; write = 1'b1;
    cyc();
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [7:0] v, input string nm);
    addr = a; lit_do = v; lit_do_en = 1'b1; lit_name = nm;
    cyc();
    lit_do_en = 1'b0;
  endtask

  // Returns the cycle index of the vblank rising edge.
  task automatic pulse(output int e);
    vblank = 1'b1; e = cyc_cnt;
    cyc();
    vblank = 1'b0;
    cyc();
  endtask

  int e1, e2, e3;

  initial begin
    // Reset
    cyc(); cyc();
    lit_do = 8'h00; lit_rd = 8'h00; lit_do_en = 1'b1; lit_rd_en = 1'b1; lit_name = "reset_outputs";
    cyc();
    reset = 1'b0;
    lit_do_en = 1'b0; lit_rd_en = 1'b0;
    rd_chk(A_STATUS, 8'h00, "reset_status");

    // Edges without a request
    for (int i = 0; i < 3; i++) pulse(e1);
    rd_chk(A_STALE, 8'h03, "stale_three");
    rd_chk(A_STATUS, 8'h00, "no_swap_front0");
    wr(16'hFE03, 8'h5A);
    rd_chk(A_STALE, 8'h00, "stale_cleared");

    // Swap commit; renderer sees new front on the first read after the edge
    wr(16'h0000, 8'h03);
    wr(A_CTRL, 8'h01);
    rd_addr = '0;
    vblank = 1'b1; e1 = cyc_cnt;
    cyc();
    vblank = 1'b0;
    lit_rd = 8'h03; lit_rd_en = 1'b1; lit_name = "render_new_front";
    cyc();
    lit_rd_en = 1'b0;
    rd_chk(A_STATUS, AUTOCLR ? 8'h06 : 8'h02, "status_after_swap");
    rd_chk(A_SWAPS, 8'h01, "swaps_one");

    // Clear window
    wait_until(e1 + 10); wr(16'h0005, 8'h55);
    wait_until(e1 + 20); rd_chk(16'h0005, AUTOCLR ? 8'h00 : 8'h55, "read_during_clear");
    wait_until(e1 + 512); wr(16'h0006, 8'h66);
    wr(16'h0007, 8'hA7);
    rd_chk(16'h0007, 8'hA7, "write_at_513_kept");
    rd_chk(16'h0006, AUTOCLR ? 8'h00 : 8'h66, "write_at_512");
    rd_chk(16'h0005, AUTOCLR ? 8'h00 : 8'h55, "write_at_10");
    for (int i = 0; i < N; i++) begin
      addr = 16'(i);
      cyc();
    end

    // Same-cycle race
    wr(A_STALE, 8'h00);
    vblank = 1'b1; addr = A_CTRL; data_in = 8'h01; write = 1'b1;
    cyc();
    vblank = 1'b0;
    cyc();
    rd_chk(A_SWAPS, 8'h01, "race_no_swap");
    rd_chk(A_STALE, 8'h01, "race_stale");
    rd_chk(A_STATUS, 8'h03, "race_pending");
    pulse(e2);
    rd_chk(A_SWAPS, 8'h02, "race_next_edge_swaps");
    rd_chk(A_STATUS, AUTOCLR ? 8'h04 : 8'h00, "race_next_edge_status");

    // Pending held through a busy clear
    wait_until(e2 + 5); wr(A_CTRL, 8'h01);
    wr(A_STALE, 8'h00);
    wait_until(e2 + 100);
    pulse(e3);
    rd_chk(A_SWAPS, AUTOCLR ? 8'h02 : 8'h03, "busy_edge_swaps");
    rd_chk(A_STALE, AUTOCLR ? 8'h01 : 8'h00, "busy_edge_stale");
    rd_chk(A_STATUS, AUTOCLR ? 8'h05 : 8'h02, "busy_edge_status");
    wait_until(e2 + 520);
    pulse(e3);
    rd_chk(A_SWAPS, 8'h03, "after_clear_swaps");
    rd_chk(A_STATUS, AUTOCLR ? 8'h06 : 8'h02, "after_clear_status");

    // Reset in the middle of a clear
    wait_until(e3 + 600);
    wr(A_CTRL, 8'h01);
    pulse(e3);
    wait_until(e3 + 50);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd_chk(A_STATUS, 8'h00, "reset_mid_clear_status");
    rd_chk(A_SWAPS, 8'h00, "reset_mid_clear_swaps");
    wr(16'h0010, 8'h99);
    rd_chk(16'h0010, 8'h99, "write_after_reset");
    for (int i = 0; i < 64; i++) begin
      addr = 16'(i);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
